// File: rtl/bcd_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_counter_pkg
//
// Shared definitions for the two-digit BCD up/down counter:
//   - rpt_state_e   : auto-repeat FSM states (IDLE, HOLD, REPEAT)
//   - SEG_DIGIT_0..9: active-high seven-segment patterns, bit order
//                     {A,B,C,D,E,F,G} with bit 6 = A
//   - bcd_to_seg()  : 4-bit BCD digit -> active-high pattern (all-off for
//                     non-BCD codes)
//   - bin_to_bcd8() : 0..99 binary value -> two packed BCD digits
// No ports (package).
// -----------------------------------------------------------------------------
package bcd_counter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    localparam logic [6:0] SEG_DIGIT_0 = 7'b1111110;
    localparam logic [6:0] SEG_DIGIT_1 = 7'b0110000;
    localparam logic [6:0] SEG_DIGIT_2 = 7'b1101101;
    localparam logic [6:0] SEG_DIGIT_3 = 7'b1111001;
    localparam logic [6:0] SEG_DIGIT_4 = 7'b0110011;
    localparam logic [6:0] SEG_DIGIT_5 = 7'b1011011;
    localparam logic [6:0] SEG_DIGIT_6 = 7'b1011111;
    localparam logic [6:0] SEG_DIGIT_7 = 7'b1110000;
    localparam logic [6:0] SEG_DIGIT_8 = 7'b1111111;
    localparam logic [6:0] SEG_DIGIT_9 = 7'b1111011;
    localparam logic [6:0] SEG_OFF     = 7'b0000000;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_DIGIT_0;
            4'd1:    seg = SEG_DIGIT_1;
            4'd2:    seg = SEG_DIGIT_2;
            4'd3:    seg = SEG_DIGIT_3;
            4'd4:    seg = SEG_DIGIT_4;
            4'd5:    seg = SEG_DIGIT_5;
            4'd6:    seg = SEG_DIGIT_6;
            4'd7:    seg = SEG_DIGIT_7;
            4'd8:    seg = SEG_DIGIT_8;
            4'd9:    seg = SEG_DIGIT_9;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    function automatic logic [7:0] bin_to_bcd8(input int value);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(value / 10);
        units = 4'(value % 10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/switch_sync_debounce.sv
// -----------------------------------------------------------------------------
// switch_sync_debounce
//
// Brings one raw, asynchronous, active-high switch into the i_Clk domain
// through a 2-flop synchroniser and then filters contact bounce.  The filtered
// output only changes after the synchronised input has disagreed with it for
// DEBOUNCE_LIMIT consecutive cycles; any shorter excursion is discarded.
//
// Ports:
//   i_Clk    in   system clock
//   i_Rst_L  in   asynchronous active-low reset (everything clears to 0)
//   i_Switch in   raw switch level
//   o_Switch out  synchronised, debounced switch level
// -----------------------------------------------------------------------------
module switch_sync_debounce #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch
);

    // Counter only has to reach DEBOUNCE_LIMIT-1.
    localparam int CNT_W = (DEBOUNCE_LIMIT < 2) ? 1 : $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    always_comb begin
        meta_d = i_Switch;
        sync_d = meta_q;
        filt_d = filt_q;
        cnt_d  = '0;
        // Counter runs only while input and filtered value disagree; any
        // agreement (a bounce back) throws the accumulated count away.
        if (sync_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_Switch = filt_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//
// Two-digit BCD up/down counter driven by two push-buttons, with per-button
// synchronise/debounce, configurable modulus (MAX_COUNT), wrap or saturate at
// the limits (WRAP), hold-to-auto-repeat (HOLD_CYCLES / REPEAT_CYCLES) and
// seven-segment drive for both digits (SEG_ACTIVE_LOW for common-anode parts).
//
// Ports:
//   i_Clk         in   system clock (only clock)
//   i_Rst_L       in   asynchronous active-low reset
//   i_Switch_Up   in   raw up button, active-high, asynchronous
//   i_Switch_Down in   raw down button, active-high, asynchronous
//   o_Count       out  [7:4] tens digit, [3:0] units digit (BCD)
//   o_Segment1    out  tens digit segments {A..G}, bit 6 = A
//   o_Segment2    out  units digit segments {A..G}, bit 6 = A
//   o_Wrap        out  one-cycle pulse when a step wraps in either direction
// -----------------------------------------------------------------------------
module bcd_updown_counter
    import bcd_counter_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int MAX_COUNT      = 99,
    parameter int WRAP           = 1,
    parameter int HOLD_CYCLES    = 12500000,
    parameter int REPEAT_CYCLES  = 2500000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch_Up,
    input  logic       i_Switch_Down,
    output logic [7:0] o_Count,
    output logic [6:0] o_Segment1,
    output logic [6:0] o_Segment2,
    output logic       o_Wrap
);

    localparam logic [7:0] MAX_BCD = bin_to_bcd8(MAX_COUNT);

    // One timer serves both the hold delay and the repeat interval.
    localparam int TIMER_SPAN = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TIMER_W    = (TIMER_SPAN < 2) ? 1 : $clog2(TIMER_SPAN);
    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);

    localparam logic [6:0] SEG_ZERO_OUT = (SEG_ACTIVE_LOW != 0) ? ~SEG_DIGIT_0 : SEG_DIGIT_0;

    // Board polarity applied on top of the active-high pattern.
    function automatic logic [6:0] seg_drive(input logic [3:0] digit);
        logic [6:0] seg;
        seg = bcd_to_seg(digit);
        return (SEG_ACTIVE_LOW != 0) ? ~seg : seg;
    endfunction

    // Returns {wrapped, next_count}.  At the top limit either wraps to 00 or
    // saturates; otherwise the units digit carries into the tens digit.
    function automatic logic [8:0] step_up(input logic [7:0] cnt);
        if (cnt == MAX_BCD)
            return (WRAP != 0) ? {1'b1, 8'h00} : {1'b0, cnt};
        if (cnt[3:0] == 4'd9)
            return {1'b0, cnt[7:4] + 4'd1, 4'd0};
        return {1'b0, cnt[7:4], cnt[3:0] + 4'd1};
    endfunction

    // Returns {wrapped, next_count}.  At 00 either wraps to MAX_COUNT or
    // saturates; otherwise the units digit borrows from the tens digit.
    function automatic logic [8:0] step_down(input logic [7:0] cnt);
        if (cnt == 8'h00)
            return (WRAP != 0) ? {1'b1, MAX_BCD} : {1'b0, cnt};
        if (cnt[3:0] == 4'd0)
            return {1'b0, cnt[7:4] - 4'd1, 4'd9};
        return {1'b0, cnt[7:4], cnt[3:0] - 4'd1};
    endfunction

    // ---------------------------------------------------------------------
    // Button conditioning
    // ---------------------------------------------------------------------
    logic up_filt;
    logic dn_filt;

    switch_sync_debounce #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_debounce_up (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Switch(i_Switch_Up),
        .o_Switch(up_filt)
    );

    switch_sync_debounce #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_debounce_down (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Switch(i_Switch_Down),
        .o_Switch(dn_filt)
    );

    // ---------------------------------------------------------------------
    // Rising-edge detection on the filtered buttons
    // ---------------------------------------------------------------------
    logic up_dly_q, up_dly_d;
    logic dn_dly_q, dn_dly_d;
    logic up_rise;
    logic dn_rise;

    always_comb begin
        up_dly_d = up_filt;
        dn_dly_d = dn_filt;
        up_rise  = up_filt & ~up_dly_q;
        dn_rise  = dn_filt & ~dn_dly_q;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            up_dly_q <= 1'b0;
            dn_dly_q <= 1'b0;
        end else begin
            up_dly_q <= up_dly_d;
            dn_dly_q <= dn_dly_d;
        end
    end

    // ---------------------------------------------------------------------
    // Auto-repeat FSM
    // ---------------------------------------------------------------------
    rpt_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               dir_up_q, dir_up_d;
    logic               rpt_step;
    logic               active_btn;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        dir_up_d   = dir_up_q;
        rpt_step   = 1'b0;
        active_btn = dir_up_q ? up_filt : dn_filt;

        case (state_q)
            IDLE: begin
                // HOLD_CYCLES == 0 leaves the FSM parked here permanently.
                if ((HOLD_CYCLES != 0) && (up_filt ^ dn_filt)) begin
                    state_d  = HOLD;
                    timer_d  = '0;
                    dir_up_d = up_filt;
                end
            end
            HOLD: begin
                if (timer_q == HOLD_LAST) begin
                    state_d  = REPEAT;
                    timer_d  = '0;
                    rpt_step = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REPEAT: begin
                if (timer_q == REPEAT_LAST) begin
                    timer_d  = '0;
                    rpt_step = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        // Releasing the held button or adding the other one cancels any
        // step that would otherwise have fired this cycle.
        if ((state_q != IDLE) && ((up_filt && dn_filt) || !active_btn)) begin
            state_d  = IDLE;
            timer_d  = '0;
            rpt_step = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            dir_up_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            dir_up_q <= dir_up_d;
        end
    end

    // ---------------------------------------------------------------------
    // BCD count, wrap pulse and segment registers
    // ---------------------------------------------------------------------
    logic       up_req;
    logic       dn_req;
    logic [8:0] step_res;
    logic [7:0] count_q, count_d;
    logic       wrap_q,  wrap_d;
    logic [6:0] seg1_q,  seg1_d;
    logic [6:0] seg2_q,  seg2_d;

    always_comb begin
        up_req   = up_rise | (rpt_step & dir_up_q);
        dn_req   = dn_rise | (rpt_step & ~dir_up_q);
        step_res = {1'b0, count_q};
        // Simultaneous up and down requests cancel out.
        if (up_req && !dn_req) begin
            step_res = step_up(count_q);
        end else if (dn_req && !up_req) begin
            step_res = step_down(count_q);
        end
        wrap_d  = step_res[8];
        count_d = step_res[7:0];
        // Segments are decoded from the next count so they change on the
        // same edge as o_Count.
        seg1_d  = seg_drive(count_d[7:4]);
        seg2_d  = seg_drive(count_d[3:0]);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count_q <= 8'h00;
            wrap_q  <= 1'b0;
            seg1_q  <= SEG_ZERO_OUT;
            seg2_q  <= SEG_ZERO_OUT;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            seg1_q  <= seg1_d;
            seg2_q  <= seg2_d;
        end
    end

    assign o_Count    = count_q;
    assign o_Wrap     = wrap_q;
    assign o_Segment1 = seg1_q;
    assign o_Segment2 = seg2_q;

endmodule
